// File: rtl/sha256_iter_core_if.sv
// Block/digest handshake bundle between the padding front end and sha256_iter_core.
// i_mode exists only when SHA2_SHA224_EN is defined.
interface sha256_iter_core_if;
    logic         i_start;
    logic         i_first;
`ifdef SHA2_SHA224_EN
    logic         i_mode;
`endif
    logic [511:0] i_data;
    logic         o_ready;
    logic         o_busy;
    logic         o_done;
    logic [255:0] o_vout;

`ifdef SHA2_SHA224_EN
    modport master (output i_start, i_first, i_mode, i_data,
                    input  o_ready, o_busy, o_done, o_vout);
    modport slave  (input  i_start, i_first, i_mode, i_data,
                    output o_ready, o_busy, o_done, o_vout);
`else
    modport master (output i_start, i_first, i_data,
                    input  o_ready, o_busy, o_done, o_vout);
    modport slave  (input  i_start, i_first, i_data,
                    output o_ready, o_busy, o_done, o_vout);
`endif
endinterface

// File: rtl/sha256_iter_core.sv
// Iterative SHA-256 compression core, RPC rounds per clock, internally held chaining value.
// Optional SHA-224 mode (IV select + truncated output) is enabled by defining SHA2_SHA224_EN.
module sha256_iter_core #(
    parameter int RPC = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    sha256_iter_core_if.slave bus
);

    generate
        if (RPC != 1 && RPC != 2 && RPC != 4) begin : g_bad_rpc
            $error("sha256_iter_core: RPC must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
`ifdef SHA2_SHA224_EN
    localparam logic [255:0] IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };
`endif

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    state_t        state, state_next;
    logic [5:0]    count, count_next, k_idx;
    logic [31:0]   w [16];
    logic [31:0]   wk [8];
    logic [31:0]   hv [8];
    logic [31:0]   w_rnd [16];
    logic [31:0]   wk_rnd [8];
    logic [31:0]   t1, t2, w_new;
    logic [255:0]  digest_new, iv_sel, vout_q;
    logic          done_q, ready_c, busy_c, accept, do_round, do_final;
`ifdef SHA2_SHA224_EN
    logic          mode_q;
`endif

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    assign count_next = count + 6'(RPC);

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    // The round counter wrapping to zero marks the last round batch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.i_start) state_next = ROUND;
            ROUND:   if (count_next == 6'd0) state_next = FINAL;
            FINAL:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_c  = (state == IDLE);
        busy_c   = (state == ROUND) || (state == FINAL);
        accept   = ready_c && bus.i_start;
        do_round = (state == ROUND);
        do_final = (state == FINAL);
    end

    always_comb begin
        iv_sel = IV256;
`ifdef SHA2_SHA224_EN
        if (bus.i_mode) iv_sel = IV224;
`endif
    end

    // Chain RPC rounds combinationally; W[0] of the shift register is always W[t] for the current round.
    always_comb begin
        w_rnd  = w;
        wk_rnd = wk;
        t1     = '0;
        t2     = '0;
        w_new  = '0;
        k_idx  = count;
        for (int r = 0; r < RPC; r++) begin
            k_idx = count + 6'(r);
            t1 = wk_rnd[7] + bsig1(wk_rnd[4]) + ((wk_rnd[4] & wk_rnd[5]) ^ (~wk_rnd[4] & wk_rnd[6]))
                 + K[k_idx] + w_rnd[0];
            t2 = bsig0(wk_rnd[0]) + ((wk_rnd[0] & wk_rnd[1]) ^ (wk_rnd[0] & wk_rnd[2]) ^ (wk_rnd[1] & wk_rnd[2]));
            w_new = ssig1(w_rnd[14]) + w_rnd[9] + ssig0(w_rnd[1]) + w_rnd[0];
            for (int i = 0; i < 15; i++) w_rnd[i] = w_rnd[i + 1];
            w_rnd[15] = w_new;
            for (int i = 7; i > 0; i--) wk_rnd[i] = wk_rnd[i - 1];
            wk_rnd[4] = wk_rnd[4] + t1;
            wk_rnd[0] = t1 + t2;
        end
    end

    always_comb begin
        digest_new = '0;
        for (int i = 0; i < 8; i++) digest_new[255 - 32*i -: 32] = wk[i] + hv[i];
    end

    // hv keeps the full H0..H7 for chaining even when the visible SHA-224 output is truncated.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count  <= '0;
            done_q <= 1'b0;
            vout_q <= '0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
            for (int i = 0; i < 8; i++) begin
                wk[i] <= '0;
                hv[i] <= '0;
            end
`ifdef SHA2_SHA224_EN
            mode_q <= 1'b0;
`endif
        end else begin
            done_q <= do_final;
            if (accept) begin
                count <= '0;
                for (int i = 0; i < 16; i++) w[i] <= bus.i_data[511 - 32*i -: 32];
                for (int i = 0; i < 8; i++) begin
                    if (bus.i_first) begin
                        hv[i] <= iv_sel[255 - 32*i -: 32];
                        wk[i] <= iv_sel[255 - 32*i -: 32];
                    end else begin
                        wk[i] <= hv[i];
                    end
                end
`ifdef SHA2_SHA224_EN
                mode_q <= bus.i_mode;
`endif
            end else if (do_round) begin
                count <= count_next;
                w     <= w_rnd;
                wk    <= wk_rnd;
            end else if (do_final) begin
                for (int i = 0; i < 8; i++) hv[i] <= digest_new[255 - 32*i -: 32];
`ifdef SHA2_SHA224_EN
                vout_q <= mode_q ? {digest_new[255:32], 32'h0} : digest_new;
`else
                vout_q <= digest_new;
`endif
            end
        end
    end

    assign bus.o_ready = ready_c;
    assign bus.o_busy  = busy_c;
    assign bus.o_done  = done_q;
    assign bus.o_vout  = vout_q;

endmodule

// File: tb/tb_sha256_iter_core.sv
// Bench for sha256_iter_core: three instances (RPC 1/2/4) share stimulus and are checked
// against known digests and a plain-array SHA-256 reference model.
module tb_sha256_iter_core;

    localparam logic [511:0] BLK_ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] BLK_M1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_M2 = {{15{32'h0}}, 32'h000001c0};
    localparam logic [255:0] EXP_ABC = {
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223, 32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    localparam logic [255:0] EXP_M = {
        32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039, 32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
    localparam logic [255:0] EXP_ABC224 = {
        32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3, 32'h2aadbce4, 32'hbda0b3f7, 32'he36c9da7, 32'h00000000};

    localparam logic [31:0] KT [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    typedef struct {
        logic [511:0] data;
        logic         first;
        logic         mode;
        logic [255:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         first;
    logic [511:0] data;
    logic [2:0]   en;
`ifdef SHA2_SHA224_EN
    logic         mode;
`endif

    int           tests_run = 0;
    int           tests_failed = 0;
    int           rpc_of [3] = '{1, 2, 4};
    int           res_lat [3];
    int           res_pulses [3];
    logic [255:0] res_vout [3];
    logic         done_v [3];
    logic         ready_v [3];
    logic         busy_v [3];
    logic [255:0] vout_v [3];
    vec_t         vecs [$];
    logic [255:0] fill_chain;

    always #5 clk = ~clk;

    sha256_iter_core_if bus1 ();
    sha256_iter_core_if bus2 ();
    sha256_iter_core_if bus4 ();

    assign bus1.i_start = start & en[0];
    assign bus2.i_start = start & en[1];
    assign bus4.i_start = start & en[2];
    assign bus1.i_first = first;
    assign bus2.i_first = first;
    assign bus4.i_first = first;
    assign bus1.i_data  = data;
    assign bus2.i_data  = data;
    assign bus4.i_data  = data;
`ifdef SHA2_SHA224_EN
    assign bus1.i_mode  = mode;
    assign bus2.i_mode  = mode;
    assign bus4.i_mode  = mode;
`endif

    sha256_iter_core #(.RPC(1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));
    sha256_iter_core #(.RPC(2)) dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2));
    sha256_iter_core #(.RPC(4)) dut4 (.i_clk(clk), .i_rst(rst), .bus(bus4));

    assign done_v[0]  = bus1.o_done;
    assign done_v[1]  = bus2.o_done;
    assign done_v[2]  = bus4.o_done;
    assign ready_v[0] = bus1.o_ready;
    assign ready_v[1] = bus2.o_ready;
    assign ready_v[2] = bus4.o_ready;
    assign busy_v[0]  = bus1.o_busy;
    assign busy_v[1]  = bus2.o_busy;
    assign busy_v[2]  = bus4.o_busy;
    assign vout_v[0]  = bus1.o_vout;
    assign vout_v[1]  = bus2.o_vout;
    assign vout_v[2]  = bus4.o_vout;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] refIv(input logic m);
        if (m) return {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                       32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
        return {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    endfunction

    // Textbook compression: expand the full 64-word schedule, then run the 64 rounds.
    function automatic logic [255:0] refCompress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  s0, s1, ch, maj, t1, t2;
        logic [255:0] hout;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            s1  = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
            ch  = (v[4] & v[5]) ^ (~v[4] & v[6]);
            t1  = v[7] + s1 + ch + KT[t] + w[t];
            s0  = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
            maj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
            t2  = s0 + maj;
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) hout[255 - 32*i -: 32] = v[i] + hin[255 - 32*i -: 32];
        return hout;
    endfunction

    function automatic logic [511:0] randBlock();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom;
        return b;
    endfunction

    // Expected output is the known constant when given, otherwise the reference model's result.
    task automatic addVec(input logic [511:0] d, input logic f, input logic m,
                          input logic use_const, input logic [255:0] kat);
        vec_t         v;
        logic [255:0] full;
        full    = refCompress(f ? refIv(m) : fill_chain, d);
        v.data  = d;
        v.first = f;
        v.mode  = m;
        v.exp   = use_const ? kat : (m ? {full[255:32], 32'h0} : full);
        vecs.push_back(v);
        fill_chain = full;
    endtask

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [511:0] d, input logic f, input logic [2:0] mask);
        @(negedge clk);
        start = 1'b1;
        data  = d;
        first = f;
        en    = mask;
        @(negedge clk);
        start = 1'b0;
        data  = randBlock();
        first = 1'($urandom);
    endtask

    // Observes 140 cycles after the accept edge; pokeN injects a start into the cycle after edge N.
    task automatic waitDone(input logic [2:0] mask, input int poke0, input int poke1, input int poke2);
        for (int k = 0; k < 3; k++) begin
            res_lat[k]    = 0;
            res_pulses[k] = 0;
            res_vout[k]   = '0;
        end
        for (int n = 1; n <= 140; n++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (mask[k]) begin
                    if (n == 1) begin
                        checkOutput($sformatf("rpc%0d_ready_low_when_busy", rpc_of[k]), 256'(ready_v[k]), 256'(0));
                        checkOutput($sformatf("rpc%0d_busy_high", rpc_of[k]), 256'(busy_v[k]), 256'(1));
                    end
                    if (done_v[k]) begin
                        res_pulses[k]++;
                        if (res_lat[k] == 0) begin
                            res_lat[k]  = n;
                            res_vout[k] = vout_v[k];
                        end
                    end
                end
            end
            start = (n == poke0) || (n == poke1) || (n == poke2);
            if (start) data = randBlock();
        end
        start = 1'b0;
    endtask

    task automatic checkBlock(input string name, input logic [255:0] exp, input logic [2:0] mask);
        for (int k = 0; k < 3; k++) begin
            if (mask[k]) begin
                checkOutput($sformatf("%s_rpc%0d_latency", name, rpc_of[k]), 256'(res_lat[k]), 256'(64 / rpc_of[k] + 1));
                checkOutput($sformatf("%s_rpc%0d_pulses", name, rpc_of[k]), 256'(res_pulses[k]), 256'(1));
                checkOutput($sformatf("%s_rpc%0d_digest", name, rpc_of[k]), res_vout[k], exp);
                checkOutput($sformatf("%s_rpc%0d_hold", name, rpc_of[k]), vout_v[k], exp);
            end
        end
    endtask

    initial begin
        int   found;
        int   late_pulses;

        rst   = 1'b1;
        start = 1'b0;
        first = 1'b0;
        data  = '0;
        en    = 3'b111;
`ifdef SHA2_SHA224_EN
        mode  = 1'b0;
`endif

        fill_chain = '0;
        addVec(randBlock(), 1'b0, 1'b0, 1'b0, '0);
        addVec(BLK_ABC, 1'b1, 1'b0, 1'b1, EXP_ABC);
        addVec(randBlock(), 1'b0, 1'b0, 1'b0, '0);
        addVec(randBlock(), 1'b1, 1'b0, 1'b0, '0);
        addVec(BLK_M1, 1'b1, 1'b0, 1'b0, '0);
        addVec(BLK_M2, 1'b0, 1'b0, 1'b1, EXP_M);
`ifdef SHA2_SHA224_EN
        addVec(BLK_ABC, 1'b1, 1'b1, 1'b1, EXP_ABC224);
        addVec(randBlock(), 1'b0, 1'b1, 1'b0, '0);
`endif
        for (int i = 0; i < 3; i++) addVec(randBlock(), 1'($urandom), 1'b0, 1'b0, '0);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("reset_rpc%0d_ready", rpc_of[k]), 256'(ready_v[k]), 256'(1));
            checkOutput($sformatf("reset_rpc%0d_busy", rpc_of[k]), 256'(busy_v[k]), 256'(0));
            checkOutput($sformatf("reset_rpc%0d_done", rpc_of[k]), 256'(done_v[k]), 256'(0));
            checkOutput($sformatf("reset_rpc%0d_vout", rpc_of[k]), vout_v[k], '0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
`ifdef SHA2_SHA224_EN
            mode = vecs[i].mode;
`endif
            applyStimulus(vecs[i].data, vecs[i].first, 3'b111);
            waitDone(3'b111, -1, -1, -1);
            checkBlock($sformatf("vec%0d", i), vecs[i].exp, 3'b111);
        end
`ifdef SHA2_SHA224_EN
        mode = 1'b0;
`endif

        // Back-to-back: second block is started in the very cycle the first one's done is seen.
        applyStimulus(BLK_M1, 1'b1, 3'b001);
        found = 0;
        for (int n = 1; n <= 100 && found == 0; n++) begin
            @(negedge clk);
            if (done_v[0]) found = 1;
        end
        checkOutput("b2b_first_done_seen", 256'(found), 256'(1));
        checkOutput("b2b_ready_on_done", 256'(ready_v[0]), 256'(1));
        checkOutput("b2b_block1_vout", vout_v[0], refCompress(refIv(1'b0), BLK_M1));
        start = 1'b1;
        data  = BLK_M2;
        first = 1'b0;
        @(negedge clk);
        start = 1'b0;
        waitDone(3'b001, -1, -1, -1);
        checkBlock("b2b_block2", EXP_M, 3'b001);

        applyStimulus(BLK_ABC, 1'b1, 3'b001);
        waitDone(3'b001, 10, 30, 64);
        checkBlock("ignored_starts", EXP_ABC, 3'b001);

        // Reset during round 20 must abort silently and clear the visible digest.
        applyStimulus(BLK_ABC, 1'b1, 3'b001);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_ready", 256'(ready_v[0]), 256'(1));
        checkOutput("midrst_busy", 256'(busy_v[0]), 256'(0));
        checkOutput("midrst_vout", vout_v[0], '0);
        late_pulses = 0;
        for (int n = 0; n < 80; n++) begin
            if (done_v[0]) late_pulses++;
            @(negedge clk);
        end
        checkOutput("midrst_no_done", 256'(late_pulses), 256'(0));
        checkOutput("midrst_vout_held", vout_v[0], '0);
        applyStimulus(BLK_ABC, 1'b1, 3'b111);
        waitDone(3'b111, -1, -1, -1);
        checkBlock("after_reset_abc", EXP_ABC, 3'b111);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
